// File: rtl/part4_chk_pkg.sv
// Shared definitions for the Part4 on-chip checker.
//   state_e      : checker FSM states
//   LFSR_W/TAPS  : 16-bit Fibonacci LFSR, feedback from bits 15,13,12,10
//   lfsr_next()  : one LFSR step (shift left, feedback into bit 0)
//   part4_expect(): cycle-accurate golden response of Part4
package part4_chk_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RST,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_e;

    localparam int              LFSR_W    = 16;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

    function automatic logic [4:0] part4_expect(input logic [5:0] inp,
                                                input logic [1:0] cnt2,
                                                input logic       tog);
        logic [4:0] e;
        e[4] = inp[5] & inp[4];
        e[3] = ~inp[3] & cnt2[1];
        e[2] = ~inp[3] & cnt2[0];
        e[1] = tog;
        e[0] = inp[0] & tog;
        return e;
    endfunction

endpackage

// File: rtl/part4_ref_model.sv
// Golden model of Part4's internal phase (2-bit counter + toggle).
//   clk, reset  : clock, synchronous active-high reset
//   clear_i     : zero the model phase (checker RST state)
//   advance_i   : step the phase by one vector (checker RUN state)
//   inp_i       : vector currently applied to Part4
//   exp_o       : expected Part4 output for inp_i in this cycle
module part4_ref_model
    import part4_chk_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       advance_i,
    input  logic [5:0] inp_i,
    output logic [4:0] exp_o
);

    logic [1:0] cnt2_q;
    logic       tog_q;

    // NOTE: sequential state is always assigned with <= so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            cnt2_q <= 2'd0;
            tog_q  <= 1'b0;
        end else if (advance_i) begin
            cnt2_q <= cnt2_q + 2'd1;
            tog_q  <= ~tog_q;
        end
    end

    assign exp_o = part4_expect(inp_i, cnt2_q, tog_q);

endmodule

// File: rtl/part4_checker.sv
// Self-checking stimulus/response block for Part4.
//   clk, reset     : clock, synchronous active-high reset
//   start          : begin a run (accepted in IDLE/DONE only)
//   dut_reset      : Part4 reset, high for the single RST cycle
//   dut_inp        : LFSR vector applied to Part4.inpBus
//   dut_out        : Part4.outBus, compared combinationally each RUN cycle
//   busy/done/pass : run status
//   err_count      : mismatching vectors, saturating
//   first_err_idx  : vector index of first mismatch
//   first_err_bits : expected ^ actual at first mismatch
module part4_checker
    import part4_chk_pkg::*;
#(
    parameter int unsigned NUM_VEC = 256,
    parameter logic [15:0] SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        dut_reset,
    output logic [5:0]  dut_inp,
    input  logic [4:0]  dut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [15:0] first_err_idx,
    output logic [4:0]  first_err_bits
);

    // An all-zero LFSR would lock up, so a zero seed is remapped.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [15:0] LAST_IDX = 16'(NUM_VEC - 1);

    state_e      state_q;
    logic [15:0] lfsr_q;
    logic [15:0] vec_idx_q;
    logic        dut_reset_q, busy_q, done_q, pass_q;
    logic [5:0]  dut_inp_q;

    // Compare result of the previous RUN cycle, committed one cycle later.
    logic        cmp_valid_q;
    logic [4:0]  cmp_bits_q;
    logic [15:0] cmp_idx_q;

    logic [15:0] err_count_q, err_count_d;
    logic [15:0] first_idx_q, first_idx_d;
    logic [4:0]  first_bits_q, first_bits_d;

    logic [4:0]  exp_w;

    part4_ref_model u_ref (
        .clk       (clk),
        .reset     (reset),
        .clear_i   (state_q == ST_RST),
        .advance_i (state_q == ST_RUN),
        .inp_i     (dut_inp_q),
        .exp_o     (exp_w)
    );

    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        err_count_d  = err_count_q;
        first_idx_d  = first_idx_q;
        first_bits_d = first_bits_q;
        if (cmp_valid_q && (cmp_bits_q != 5'd0)) begin
            if (err_count_q == 16'd0) begin
                first_idx_d  = cmp_idx_q;
                first_bits_d = cmp_bits_q;
            end
            if (err_count_q != 16'hFFFF) begin
                err_count_d = err_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            lfsr_q       <= SEED_EFF;
            vec_idx_q    <= 16'd0;
            dut_reset_q  <= 1'b0;
            dut_inp_q    <= 6'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            cmp_valid_q  <= 1'b0;
            cmp_bits_q   <= 5'd0;
            cmp_idx_q    <= 16'd0;
            err_count_q  <= 16'd0;
            first_idx_q  <= 16'd0;
            first_bits_q <= 5'd0;
        end else begin
            cmp_valid_q  <= 1'b0;
            err_count_q  <= err_count_d;
            first_idx_q  <= first_idx_d;
            first_bits_q <= first_bits_d;

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q      <= ST_RST;
                        dut_reset_q  <= 1'b1;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        lfsr_q       <= SEED_EFF;
                        vec_idx_q    <= 16'd0;
                        err_count_q  <= 16'd0;
                        first_idx_q  <= 16'd0;
                        first_bits_q <= 5'd0;
                    end
                end
                ST_RST: begin
                    state_q     <= ST_RUN;
                    dut_reset_q <= 1'b0;
                    dut_inp_q   <= lfsr_q[5:0];
                    lfsr_q      <= lfsr_next(lfsr_q);
                end
                ST_RUN: begin
                    cmp_valid_q <= 1'b1;
                    cmp_bits_q  <= exp_w ^ dut_out;
                    cmp_idx_q   <= vec_idx_q;
                    vec_idx_q   <= vec_idx_q + 16'd1;
                    if (vec_idx_q == LAST_IDX) begin
                        state_q <= ST_FLUSH;
                    end else begin
                        dut_inp_q <= lfsr_q[5:0];
                        lfsr_q    <= lfsr_next(lfsr_q);
                    end
                end
                ST_FLUSH: begin
                    // The last compare commits on this edge, so pass uses
                    // the post-commit count.
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (err_count_d == 16'd0);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign dut_reset      = dut_reset_q;
    assign dut_inp        = dut_inp_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_idx  = first_idx_q;
    assign first_err_bits = first_bits_q;

endmodule

// File: tb/tb_part4_checker.sv
// Directed bench for part4_checker. Four checker instances, each driving a
// behavioural Part4 stand-in with selectable output faults:
//   0: NUM_VEC=256, SEED=ACE1   1: NUM_VEC=1, SEED=ACE1
//   2: NUM_VEC=3,   SEED=0      3: NUM_VEC=1, SEED=0030
module tb_part4_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_v          [4];
    logic        dut_reset_v      [4];
    logic [5:0]  dut_inp_v        [4];
    logic [4:0]  dut_out_v        [4];
    logic        busy_v           [4];
    logic        done_v           [4];
    logic        pass_v           [4];
    logic [15:0] err_count_v      [4];
    logic [15:0] first_err_idx_v  [4];
    logic [4:0]  first_err_bits_v [4];

    // Part4 stand-in: free-running 2-bit counter and toggle, cleared by dut_reset.
    logic [1:0]  p4_cnt [4];
    logic        p4_tog [4];
    int          mode_v [4];   // 0 golden, 1 outBus[1] stuck 0, 2 outBus stuck 0

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    part4_checker #(.NUM_VEC(256), .SEED(16'hACE1)) u_dut0 (
        .clk(clk), .reset(reset), .start(start_v[0]), .dut_reset(dut_reset_v[0]),
        .dut_inp(dut_inp_v[0]), .dut_out(dut_out_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .err_count(err_count_v[0]), .first_err_idx(first_err_idx_v[0]),
        .first_err_bits(first_err_bits_v[0]));
    part4_checker #(.NUM_VEC(1), .SEED(16'hACE1)) u_dut1 (
        .clk(clk), .reset(reset), .start(start_v[1]), .dut_reset(dut_reset_v[1]),
        .dut_inp(dut_inp_v[1]), .dut_out(dut_out_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .err_count(err_count_v[1]), .first_err_idx(first_err_idx_v[1]),
        .first_err_bits(first_err_bits_v[1]));
    part4_checker #(.NUM_VEC(3), .SEED(16'h0000)) u_dut2 (
        .clk(clk), .reset(reset), .start(start_v[2]), .dut_reset(dut_reset_v[2]),
        .dut_inp(dut_inp_v[2]), .dut_out(dut_out_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .err_count(err_count_v[2]), .first_err_idx(first_err_idx_v[2]),
        .first_err_bits(first_err_bits_v[2]));
    part4_checker #(.NUM_VEC(1), .SEED(16'h0030)) u_dut3 (
        .clk(clk), .reset(reset), .start(start_v[3]), .dut_reset(dut_reset_v[3]),
        .dut_inp(dut_inp_v[3]), .dut_out(dut_out_v[3]), .busy(busy_v[3]), .done(done_v[3]),
        .pass(pass_v[3]), .err_count(err_count_v[3]), .first_err_idx(first_err_idx_v[3]),
        .first_err_bits(first_err_bits_v[3]));

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (dut_reset_v[k]) begin
                p4_cnt[k] <= 2'd0;
                p4_tog[k] <= 1'b0;
            end else begin
                p4_cnt[k] <= p4_cnt[k] + 2'd1;
                p4_tog[k] <= ~p4_tog[k];
            end
        end
    end

    function automatic logic [4:0] part4_stub(input logic [5:0] i, input logic [1:0] c,
                                              input logic t, input int mode);
        logic [4:0] o;
        o = {(i[5:4] == 2'b11), (i[3] ? 2'b00 : c), t, t ? i[0] : 1'b0};
        if (mode == 1) o[1] = 1'b0;
        if (mode == 2) o = 5'd0;
        return o;
    endfunction

    for (genvar k = 0; k < 4; k++) begin : g_p4
        assign dut_out_v[k] = part4_stub(dut_inp_v[k], p4_cnt[k], p4_tog[k], mode_v[k]);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Starts a run on instance k (start sampled at edge 0) and steps until done
    // or the cycle budget expires. Collects the first three applied vectors,
    // whether every RUN vector matched an independent LFSR, whether busy and
    // dut_reset followed the cycle plan, and whether status was clear in RST.
    task automatic do_run(input int k, input int n, input logic [15:0] seed,
                          input bit pulse_mid, output int done_cyc, output logic [17:0] f3,
                          output bit inp_ok, output bit busy_ok, output bit clr_ok);
        logic [15:0] l;
        done_cyc = -1;
        f3       = '0;
        inp_ok   = 1'b1;
        busy_ok  = 1'b1;
        l        = (seed == 16'h0000) ? 16'h0001 : seed;
        start_v[k] = 1'b1;
        step();
        start_v[k] = 1'b0;
        if (!(busy_v[k] === 1'b1 && dut_reset_v[k] === 1'b1 && done_v[k] === 1'b0)) busy_ok = 1'b0;
        clr_ok = (err_count_v[k] === 16'd0) && (first_err_idx_v[k] === 16'd0) &&
                 (first_err_bits_v[k] === 5'd0) && (pass_v[k] === 1'b0);
        for (int c = 2; c <= n + 10; c++) begin
            if (pulse_mid && c == 20) start_v[k] = 1'b1;
            step();
            start_v[k] = 1'b0;
            if (c == 2) f3[17:12] = dut_inp_v[k];
            if (c == 3) f3[11:6]  = dut_inp_v[k];
            if (c == 4) f3[5:0]   = dut_inp_v[k];
            if (c <= n + 1) begin
                if (dut_inp_v[k] !== l[5:0] || busy_v[k] !== 1'b1 || dut_reset_v[k] !== 1'b0)
                    inp_ok = 1'b0;
                l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            end
            if (c == n + 2 && (busy_v[k] !== 1'b1 || done_v[k] !== 1'b0)) busy_ok = 1'b0;
            if (done_v[k] === 1'b1) begin
                done_cyc = c;
                if (busy_v[k] !== 1'b0) busy_ok = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        int          dc;
        logic [17:0] f3;
        bit          inp_ok, busy_ok, clr_ok;

        for (int k = 0; k < 4; k++) begin
            start_v[k] = 1'b0;
            mode_v[k]  = 0;
        end
        mode_v[1] = 2;
        mode_v[3] = 2;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        check("rst_dut_reset", dut_reset_v[0], 0);
        check("rst_dut_inp",   dut_inp_v[0], 0);
        check("rst_busy",      busy_v[0], 0);
        check("rst_done",      done_v[0], 0);
        check("rst_pass",      pass_v[0], 0);
        check("rst_err",       err_count_v[0], 0);
        check("rst_first_idx", first_err_idx_v[0], 0);
        check("rst_first_bits", first_err_bits_v[0], 0);

        // Golden run, 256 vectors.
        do_run(0, 256, 16'hACE1, 1'b0, dc, f3, inp_ok, busy_ok, clr_ok);
        check("a_done_cycle", dc, 259);
        check("a_first3",     f3, {6'h21, 6'h03, 6'h07});
        check("a_inp_seq",    inp_ok, 1);
        check("a_busy_seq",   busy_ok, 1);
        check("a_pass",       pass_v[0], 1);
        check("a_err",        err_count_v[0], 0);
        repeat (3) step();
        check("a_done_held",  done_v[0], 1);
        check("a_dut_reset",  dut_reset_v[0], 0);

        // outBus[1] stuck low: every odd vector fails.
        mode_v[0] = 1;
        do_run(0, 256, 16'hACE1, 1'b0, dc, f3, inp_ok, busy_ok, clr_ok);
        check("b_done_cycle", dc, 259);
        check("b_err",        err_count_v[0], 128);
        check("b_first_idx",  first_err_idx_v[0], 1);
        check("b_first_bits", first_err_bits_v[0], 5'b00010);
        check("b_pass",       pass_v[0], 0);

        // Re-run from DONE: status cleared in RST, same sequence, start mid-run ignored.
        mode_v[0] = 0;
        do_run(0, 256, 16'hACE1, 1'b1, dc, f3, inp_ok, busy_ok, clr_ok);
        check("c_cleared_in_rst", clr_ok, 1);
        check("c_done_cycle", dc, 259);
        check("c_first3",     f3, {6'h21, 6'h03, 6'h07});
        check("c_inp_seq",    inp_ok, 1);
        check("c_pass",       pass_v[0], 1);
        check("c_err",        err_count_v[0], 0);

        // NUM_VEC=1, outBus stuck 0, seed ACE1 -> inp 0x21, bits[5:4]=10 -> no error.
        do_run(1, 1, 16'hACE1, 1'b0, dc, f3, inp_ok, busy_ok, clr_ok);
        check("d_done_cycle", dc, 4);
        check("d_inp",        f3[17:12], 6'h21);
        check("d_err",        err_count_v[1], 0);
        check("d_pass",       pass_v[1], 1);

        // NUM_VEC=1, outBus stuck 0, seed 0030 -> inp 0x30 -> expected bit 4 set.
        do_run(3, 1, 16'h0030, 1'b0, dc, f3, inp_ok, busy_ok, clr_ok);
        check("e_done_cycle", dc, 4);
        check("e_err",        err_count_v[3], 1);
        check("e_first_idx",  first_err_idx_v[3], 0);
        check("e_first_bits", first_err_bits_v[3], 5'b10000);
        check("e_pass",       pass_v[3], 0);

        // SEED=0 remapped to 0001: vectors 01, 02, 04.
        do_run(2, 3, 16'h0000, 1'b0, dc, f3, inp_ok, busy_ok, clr_ok);
        check("f_done_cycle", dc, 6);
        check("f_first3",     f3, {6'h01, 6'h02, 6'h04});
        check("f_inp_seq",    inp_ok, 1);
        check("f_pass",       pass_v[2], 1);

        // Reset during RUN discards the run.
        start_v[0] = 1'b1;
        step();
        start_v[0] = 1'b0;
        repeat (10) step();
        check("g_busy_before_reset", busy_v[0], 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("g_busy",       busy_v[0], 0);
        check("g_dut_inp",    dut_inp_v[0], 0);
        check("g_dut_reset",  dut_reset_v[0], 0);
        check("g_done",       done_v[0], 0);
        check("g_err",        err_count_v[0], 0);
        step();
        check("g_idle_busy",  busy_v[0], 0);
        do_run(0, 256, 16'hACE1, 1'b0, dc, f3, inp_ok, busy_ok, clr_ok);
        check("g_done_cycle", dc, 259);
        check("g_inp_seq",    inp_ok, 1);
        check("g_busy_seq",   busy_ok, 1);
        check("g_pass",       pass_v[0], 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
